// File: rtl/frame_lock_monitor.sv
// frame_lock_monitor
// Watches the frame period reported by an upstream period counter and decides
// whether the incoming frame stream is locked to the nominal TARGET period.
// A watchdog flags missing frames (STALL) and counts them as bad frames.
// Optional feature: define FRAME_LOCK_MONITOR_AVG_EN to report PERIOD as the
// average of the last four periods instead of the raw latest period.
module frame_lock_monitor #(
  parameter int TARGET   = 16'h5175,
  parameter int WIN      = 16,
  parameter int LOCK_N   = 4,
  parameter int UNLOCK_N = 2,
  parameter int TIMEOUT  = 26250
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        FRAME_STB,
  input  logic [15:0] TOL,
  output logic [15:0] PERIOD,
  output logic        LOCKED,
  output logic [1:0]  STATE,
  output logic        STALL,
  output logic [7:0]  ERR_CNT
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [15:0]       TARGET_C = 16'(TARGET);
  localparam logic signed [16:0] WIN_S   = 17'(WIN);
  localparam logic [7:0]        LOCK_C   = 8'(LOCK_N);
  localparam logic [7:0]        UNLOCK_C = 8'(UNLOCK_N);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCK    = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [7:0]        good_reg, good_next;
  logic [7:0]        bad_reg, bad_next;
  logic [7:0]        err_reg, err_next;
  logic [WD_W-1:0]   wd_reg, wd_next;
  logic              stall_reg, stall_next;
  logic              locked_reg;
  logic [15:0]       period_reg, period_next;

  logic signed [16:0] diff;
  logic               in_win;
  logic               expire;
  logic               good_evt;
  logic               bad_evt;

  // Window decision on the raw period; 17-bit signed so no TOL value can wrap
  always_comb begin
    diff   = $signed({1'b0, TOL}) - $signed({1'b0, TARGET_C});
    in_win = (diff <= WIN_S) && (diff >= -WIN_S);
  end

  // Watchdog: a frame always wins over a coinciding expiry
  always_comb begin
    expire     = (wd_reg == WD_LAST);
    stall_next = expire && !FRAME_STB;
    if (FRAME_STB || expire) begin
      wd_next = '0;
    end else begin
      wd_next = wd_reg + WD_W'(1);
    end
    good_evt = FRAME_STB && in_win;
    bad_evt  = (FRAME_STB && !in_win) || stall_next;
  end

  // Lock FSM next-state and counter updates; a stall is treated as a bad frame
  always_comb begin
    state_next = state_reg;
    good_next  = good_reg;
    bad_next   = bad_reg;
    err_next   = err_reg;
    case (state_reg)
      SEARCH: begin
        if (good_evt) begin
          good_next  = 8'd1;
          bad_next   = 8'd0;
          state_next = (8'd1 >= LOCK_C) ? LOCK : ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (good_evt) begin
          if (good_reg + 8'd1 >= LOCK_C) begin
            good_next  = LOCK_C;
            bad_next   = 8'd0;
            state_next = LOCK;
          end else begin
            good_next = good_reg + 8'd1;
          end
        end else if (bad_evt) begin
          good_next  = 8'd0;
          state_next = SEARCH;
        end
      end
      LOCK: begin
        if (good_evt) begin
          bad_next = 8'd0;
        end else if (bad_evt) begin
          err_next = (err_reg == 8'hFF) ? err_reg : err_reg + 8'd1;
          if (bad_reg + 8'd1 >= UNLOCK_C) begin
            good_next  = 8'd0;
            bad_next   = 8'd0;
            state_next = SEARCH;
          end else begin
            bad_next = bad_reg + 8'd1;
          end
        end
      end
      default: begin
        good_next  = 8'd0;
        bad_next   = 8'd0;
        state_next = SEARCH;
      end
    endcase
  end

`ifdef FRAME_LOCK_MONITOR_AVG_EN
  logic [15:0] hist_reg [0:2];
  logic [1:0]  fill_reg;
  logic [17:0] sum;

  // Running average over the current and three previous periods
  always_comb begin
    sum = {2'b00, TOL} + {2'b00, hist_reg[0]} + {2'b00, hist_reg[1]} + {2'b00, hist_reg[2]};
    if (!FRAME_STB) begin
      period_next = period_reg;
    end else if (fill_reg == 2'd3) begin
      period_next = 16'(sum >> 2);
    end else begin
      period_next = TOL;
    end
  end

  // Period history shift register and fill count (saturates once full)
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 3; i++) hist_reg[i] <= '0;
      fill_reg <= '0;
    end else if (FRAME_STB) begin
      hist_reg[0] <= TOL;
      for (int i = 1; i < 3; i++) hist_reg[i] <= hist_reg[i-1];
      if (fill_reg != 2'd3) fill_reg <= fill_reg + 2'd1;
    end
  end
`else
  // Raw period: latch every frame, in-window or not
  always_comb begin
    period_next = FRAME_STB ? TOL : period_reg;
  end
`endif

  // All state and outputs registered; one cycle latency after FRAME_STB
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg  <= SEARCH;
      good_reg   <= '0;
      bad_reg    <= '0;
      err_reg    <= '0;
      wd_reg     <= '0;
      stall_reg  <= 1'b0;
      locked_reg <= 1'b0;
      period_reg <= '0;
    end else begin
      state_reg  <= state_next;
      good_reg   <= good_next;
      bad_reg    <= bad_next;
      err_reg    <= err_next;
      wd_reg     <= wd_next;
      stall_reg  <= stall_next;
      locked_reg <= (state_next == LOCK);
      period_reg <= period_next;
    end
  end

  assign PERIOD  = period_reg;
  assign LOCKED  = locked_reg;
  assign STATE   = state_reg;
  assign STALL   = stall_reg;
  assign ERR_CNT = err_reg;

endmodule

// File: tb/tb_frame_lock_monitor.sv
// tb_frame_lock_monitor
// Scoreboard bench: the driver pushes expected responses (frames and the
// stalls implied by frame gaps) into a queue; a monitor pops and compares
// whenever the DUT presents a frame result or a STALL pulse.
module tb_frame_lock_monitor;

  localparam int T_TARGET = 20853;
  localparam int T_WIN    = 16;
  localparam int T_LOCK   = 4;
  localparam int T_UNLOCK = 2;
  localparam int T_TO     = 300;

  logic        CLK;
  logic        RESET_N;
  logic        FRAME_STB;
  logic [15:0] TOL;
  logic [15:0] PERIOD;
  logic        LOCKED;
  logic [1:0]  STATE;
  logic        STALL;
  logic [7:0]  ERR_CNT;

  frame_lock_monitor #(
    .TARGET  (T_TARGET),
    .WIN     (T_WIN),
    .LOCK_N  (T_LOCK),
    .UNLOCK_N(T_UNLOCK),
    .TIMEOUT (T_TO)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .FRAME_STB(FRAME_STB),
    .TOL      (TOL),
    .PERIOD   (PERIOD),
    .LOCKED   (LOCKED),
    .STATE    (STATE),
    .STALL    (STALL),
    .ERR_CNT  (ERR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] period;
    logic        locked;
    logic [1:0]  state;
    logic        stall;
    logic [7:0]  err;
  } exp_t;

  exp_t   q[$];
  int     pass_cnt  = 0;
  int     total_cnt = 0;
  longint now       = 0;
  longint last_evt  = 0;

  // reference model, event level
  int m_state, m_good, m_bad, m_err, m_period;
  int m_hist[$];

  function automatic bit in_window(int tol);
    int d;
    d = tol - T_TARGET;
    if (d < 0) d = -d;
    return d <= T_WIN;
  endfunction

  task automatic chk(string nm, longint act, longint expv);
    total_cnt++;
    if (act == expv) begin
      pass_cnt++;
      $display("ok   %s act=%0d exp=%0d", nm, act, expv);
    end else begin
      $display("FAIL %s act=%0d exp=%0d", nm, act, expv);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_good = 0; m_bad = 0; m_err = 0; m_period = 0;
    m_hist.delete();
  endtask

  // Apply one frame (is_frame=1) or watchdog stall (is_frame=0) to the model
  task automatic model_event(bit is_frame, int tol);
    exp_t e;
    bit   good;
    int   s;
    good = is_frame && in_window(tol);
    if (is_frame) begin
      m_hist.push_back(tol);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
`ifdef FRAME_LOCK_MONITOR_AVG_EN
      if (m_hist.size() == 4) begin
        s = 0;
        foreach (m_hist[k]) s += m_hist[k];
        m_period = s / 4;
      end else begin
        m_period = tol;
      end
`else
      s = 0;
      m_period = tol + s;
`endif
    end
    case (m_state)
      0: if (good) begin
        m_good  = 1;
        m_state = (m_good >= T_LOCK) ? 2 : 1;
      end
      1: if (good) begin
        m_good++;
        if (m_good >= T_LOCK) m_state = 2;
      end else begin
        m_good = 0; m_state = 0;
      end
      default: if (good) begin
        m_bad = 0;
      end else begin
        if (m_err < 255) m_err++;
        m_bad++;
        if (m_bad >= T_UNLOCK) begin
          m_state = 0; m_good = 0; m_bad = 0;
        end
      end
    endcase
    e.period = 16'(m_period);
    e.locked = (m_state == 2);
    e.state  = 2'(m_state);
    e.stall  = !is_frame;
    e.err    = 8'(m_err);
    q.push_back(e);
  endtask

  // Stalls fall every T_TO edges after the last frame, strictly before edge e
  task automatic push_stalls_before(longint e);
    while (last_evt + T_TO < e) begin
      last_evt += T_TO;
      model_event(1'b0, 0);
    end
  endtask

  task automatic cycle(bit stb, logic [15:0] tol);
    FRAME_STB = stb;
    TOL       = tol;
    @(posedge CLK);
    now++;
    #1;
  endtask

  task automatic idle(int n);
    push_stalls_before(now + n + 1);
    repeat (n) cycle(1'b0, 16'h0);
  endtask

  task automatic frame(int tol, int gap);
    longint e;
    e = now + gap + 1;
    push_stalls_before(e);
    model_event(1'b1, tol);
    last_evt = e;
    repeat (gap) cycle(1'b0, 16'h0);
    cycle(1'b1, 16'(tol));
  endtask

  // Asynchronous reset away from the clock edge, checked before any edge
  task automatic do_reset();
    push_stalls_before(now + 1);
    FRAME_STB = 1'b0;
    @(negedge CLK);
    #2;
    chk("queue_drained_before_reset", q.size(), 0);
    RESET_N = 1'b0;
    #1;
    chk("rst_state", STATE, 0);
    chk("rst_locked", LOCKED, 0);
    chk("rst_period", PERIOD, 0);
    chk("rst_stall", STALL, 0);
    chk("rst_err", ERR_CNT, 0);
    model_reset();
    repeat (3) cycle(1'b0, 16'h0);
    RESET_N  = 1'b1;
    last_evt = now;
  endtask

  // Monitor: compare on every frame result and on every STALL pulse
  initial begin
    bit   seen;
    exp_t e;
    int   n;
    n = 0;
    forever begin
      @(posedge CLK);
      seen = (FRAME_STB === 1'b1) && (RESET_N === 1'b1);
      @(negedge CLK);
      if (seen || STALL === 1'b1) begin
        total_cnt++;
        n++;
        if (q.size() == 0) begin
          $display("FAIL txn%0d unexpected output stall=%0b state=%0d (no expectation queued)",
                   n, STALL, STATE);
        end else begin
          e = q.pop_front();
          if (PERIOD === e.period && LOCKED === e.locked && STATE === e.state &&
              STALL === e.stall && ERR_CNT === e.err) begin
            pass_cnt++;
            $display("txn%0d ok period=%0d locked=%0b state=%0d stall=%0b err=%0d",
                     n, PERIOD, LOCKED, STATE, STALL, ERR_CNT);
          end else begin
            $display("FAIL txn%0d act period=%0d locked=%0b state=%0d stall=%0b err=%0d exp period=%0d locked=%0b state=%0d stall=%0b err=%0d",
                     n, PERIOD, LOCKED, STATE, STALL, ERR_CNT,
                     e.period, e.locked, e.state, e.stall, e.err);
          end
        end
      end
    end
  end

  // Driver: directed cases first, then randomized frames
  initial begin
    int r, tol, gap;
    RESET_N   = 1'b1;
    FRAME_STB = 1'b0;
    TOL       = 16'h0;
    model_reset();
    #1 RESET_N = 1'b0;
    #1;
    chk("init_state", STATE, 0);
    chk("init_locked", LOCKED, 0);
    chk("init_period", PERIOD, 0);
    chk("init_err", ERR_CNT, 0);
    repeat (3) cycle(1'b0, 16'h0);
    RESET_N  = 1'b1;
    last_evt = now;

    // acquire and lock on four nominal frames
    repeat (4) frame(20853, 2);
    chk("lock_state", STATE, 2);
    chk("lock_locked", LOCKED, 1);
    frame(20869, 2);
    chk("delta16_locked", LOCKED, 1);
    frame(20870, 2);
    frame(20870, 2);
    chk("delta17_unlock", LOCKED, 0);
    chk("delta17_err", ERR_CNT, 2);

    // relock, then two watchdog silences
    repeat (4) frame(20853, 1);
    idle(T_TO + 5);
    chk("stall1_state", STATE, 2);
    chk("stall1_err", ERR_CNT, 3);
    idle(T_TO);
    chk("stall2_state", STATE, 0);
    chk("stall2_err", ERR_CNT, 4);

    // frame exactly on the expiry cycle
    frame(20853, 0);
    frame(20853, T_TO - 1);
    frame(20853, T_TO - 1);
    chk("coincide_state", STATE, 1);

    // extreme periods are out-of-window
    frame(0, 1);
    chk("tol0_state", STATE, 0);
    frame(20853, 1);
    frame(16'hFFFF, 1);
    chk("tolffff_state", STATE, 0);
    chk("tolffff_period", PERIOD, 65535);

    // averaging case from a fresh reset
    do_reset();
    frame(20850, 1);
    frame(20854, 1);
    frame(20858, 1);
    frame(20862, 1);
`ifdef FRAME_LOCK_MONITOR_AVG_EN
    chk("avg_period", PERIOD, 20856);
`else
    chk("raw_period", PERIOD, 20862);
`endif

    // reset in the middle of ACQUIRE
    do_reset();
    frame(20853, 1);
    frame(20853, 1);
    chk("acq_state", STATE, 1);
    do_reset();

    // randomized frames
    for (int i = 0; i < 160; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 65)      gap = int'($urandom_range(0, 6));
      else if (r < 82) gap = 0;
      else if (r < 93) gap = T_TO - 1;
      else             gap = int'($urandom_range(T_TO, 2 * T_TO + 10));
      r = int'($urandom_range(0, 99));
      if (r < 60)      tol = T_TARGET + int'($urandom_range(0, 40)) - 20;
      else if (r < 75) tol = T_TARGET + (($urandom_range(0, 1) == 0) ? -1 : 1) * (16 + int'($urandom_range(0, 1)));
      else if (r < 90) tol = int'($urandom_range(0, 65535));
      else             tol = ($urandom_range(0, 1) == 0) ? 0 : 65535;
      frame(tol, gap);
      if ($urandom_range(0, 39) == 0) do_reset();
    end

    push_stalls_before(now + 4);
    repeat (3) cycle(1'b0, 16'h0);
    #10;
    chk("queue_empty_at_end", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard bound on simulated time
  initial begin
    #3000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
